// File: rtl/bick_delay_cal.sv
// bick_delay_cal: sweeps BICK delay taps, counts sampling hazards, programs the centre of the widest clean window
module bick_delay_cal #(
    parameter int N_EDGES    = 64,
    parameter int SETTLE_CYC = 16,
    parameter int TIMEOUT    = 4096,
    parameter int ERR_W      = 7
) (
    input  logic             clk_300m,
    input  logic             rst_n,
    input  logic             cal_start,
    input  logic             manual_en,
    input  logic [2:0]       manual_setting,
    input  logic             bick_fb,
    input  logic             sdata_in,
    output logic [2:0]       delay_setting,
    output logic             cal_busy,
    output logic             cal_done,
    output logic             cal_fail,
    output logic [7:0]       zero_map,
    output logic [ERR_W-1:0] best_err
);
    localparam int EW = $clog2(N_EDGES + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [EW-1:0]    E_LAST = EW'(N_EDGES - 1);
    localparam logic [SW-1:0]    S_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0] E_MAX  = '1;
    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, NEXT, EVAL, DONE} state_t;
    state_t           state;
    logic             b_s1, b_s2, b_s3, d_s1, d_s2, d_s3;
    logic [SW-1:0]    set_cnt;
    logic [EW-1:0]    edge_cnt;
    logic [TW-1:0]    to_cnt;
    logic [ERR_W-1:0] err_cnt, min_err;
    logic [2:0]       tap, min_tap, prev_setting, idx, run_start, best_start;
    logic [3:0]       run_len, best_len;
    logic             edge_ev, hazard, bit_t, take;
    logic [3:0]       run_n, fin_len;
    logic [2:0]       start_n, fin_start, centre;
    always_ff @(posedge clk_300m or negedge rst_n) begin
        if (!rst_n) {b_s1, b_s2, b_s3, d_s1, d_s2, d_s3} <= '0;
        else {b_s1, b_s2, b_s3, d_s1, d_s2, d_s3} <= {bick_fb, b_s1, b_s2, sdata_in, d_s1, d_s2};
    end
    assign edge_ev = b_s2 & ~b_s3;
    assign hazard  = edge_ev & (d_s2 ^ d_s3);
    // Run-length scan of zero_map, one tap per EVAL cycle; strict > keeps the first longest run
    always_comb begin
        bit_t     = zero_map[idx];
        run_n     = bit_t ? run_len + 4'd1 : 4'd0;
        start_n   = (bit_t && run_len == 4'd0) ? idx : run_start;
        take      = run_n > best_len;
        fin_len   = take ? run_n : best_len;
        fin_start = take ? start_n : best_start;
        centre    = fin_start + 3'((fin_len - 4'd1) >> 1);
    end
    always_ff @(posedge clk_300m or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            delay_setting <= '0;
            cal_busy      <= 1'b0;
            cal_done      <= 1'b0;
            cal_fail      <= 1'b0;
            zero_map      <= '0;
            best_err      <= '0;
            set_cnt       <= '0;
            edge_cnt      <= '0;
            to_cnt        <= '0;
            err_cnt       <= '0;
            min_err       <= '0;
            tap           <= '0;
            min_tap       <= '0;
            prev_setting  <= '0;
            idx           <= '0;
            run_start     <= '0;
            best_start    <= '0;
            run_len       <= '0;
            best_len      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (manual_en) delay_setting <= manual_setting;
                    else if (cal_start) begin
                        prev_setting  <= delay_setting;
                        tap           <= '0;
                        delay_setting <= '0;
                        zero_map      <= '0;
                        min_err       <= E_MAX;
                        min_tap       <= '0;
                        cal_done      <= 1'b0;
                        cal_fail      <= 1'b0;
                        cal_busy      <= 1'b1;
                        set_cnt       <= '0;
                        state         <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (set_cnt == S_LAST) begin
                        edge_cnt <= '0;
                        err_cnt  <= '0;
                        to_cnt   <= '0;
                        state    <= MEASURE;
                    end else set_cnt <= set_cnt + 1'b1;
                end
                MEASURE: begin
                    if (edge_ev) begin
                        edge_cnt <= edge_cnt + 1'b1;
                        to_cnt   <= '0;
                        if (hazard && err_cnt != E_MAX) err_cnt <= err_cnt + 1'b1;
                        if (edge_cnt == E_LAST) state <= NEXT;
                    end else if (to_cnt == T_LAST) begin
                        delay_setting <= prev_setting;
                        cal_fail      <= 1'b1;
                        cal_done      <= 1'b1;
                        cal_busy      <= 1'b0;
                        state         <= DONE;
                    end else to_cnt <= to_cnt + 1'b1;
                end
                NEXT: begin
                    zero_map[tap] <= (err_cnt == '0);
                    if (err_cnt < min_err) begin
                        min_err <= err_cnt;
                        min_tap <= tap;
                    end
                    if (tap == 3'd7) begin
                        idx        <= '0;
                        run_len    <= '0;
                        run_start  <= '0;
                        best_len   <= '0;
                        best_start <= '0;
                        state      <= EVAL;
                    end else begin
                        tap           <= tap + 3'd1;
                        delay_setting <= tap + 3'd1;
                        set_cnt       <= '0;
                        state         <= SETTLE;
                    end
                end
                EVAL: begin
                    run_len    <= run_n;
                    run_start  <= start_n;
                    best_len   <= fin_len;
                    best_start <= fin_start;
                    idx        <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        delay_setting <= (fin_len != 4'd0) ? centre : min_tap;
                        best_err      <= (fin_len != 4'd0) ? '0 : min_err;
                        cal_fail      <= (fin_len == 4'd0);
                        cal_done      <= 1'b1;
                        cal_busy      <= 1'b0;
                        state         <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/bick_delay_cal.md
Name: bick_delay_cal

Overview:
Calibration controller for the 300 MHz BICK tap-delay stage. It sweeps delay_setting through taps 0..7. At each tap it counts sampling hazards: serial-data transitions that coincide with rising edges of the delayed BICK fed back from the delay stage. It then programs the centre of the longest hazard-free tap window. A manual override allows software to force a tap.

Parameters:
N_EDGES, 64, rising BICK edges measured per tap
SETTLE_CYC, 16, clk_300m cycles waited after each tap change before measuring
TIMEOUT, 4096, clk_300m cycles allowed in one tap measurement without a BICK edge before failing
ERR_W, 7, width of per-tap error counter; must hold N_EDGES

Ports:
clk_300m  in  1  sole clock
rst_n  in  1  reset, asynchronous, active-low
cal_start  in  1  single-cycle pulse, starts calibration
manual_en  in  1  1 = force manual_setting, calibration disabled
manual_setting  in  3  tap forced when manual_en=1
bick_fb  in  1  delayed BICK returned from the delay stage, asynchronous
sdata_in  in  1  serial audio data, asynchronous
delay_setting  out  3  tap select to the delay stage
cal_busy  out  1  calibration in progress
cal_done  out  1  level; set at end of calibration, cleared by next accepted cal_start
cal_fail  out  1  level; last calibration timed out or found no usable tap
zero_map  out  8  bit t=1: tap t had zero errors in the last calibration
best_err  out  ERR_W  error count of the chosen tap

Behaviour:
- Reset (rst_n=0, asynchronous): delay_setting=0 (passthrough), cal_busy=0, cal_done=0, cal_fail=0, zero_map=0, best_err=0, FSM=IDLE, all counters 0.
- Input conditioning: bick_fb and sdata_in each pass through 2-FF synchronisers (b_s2, d_s2), plus one extra stage (b_s3, d_s3).
  - Edge event = b_s2 & ~b_s3.
  - Hazard = edge event & (d_s2 != d_s3).
- FSM states: IDLE, SETTLE, MEASURE, NEXT, EVAL, DONE.
- IDLE/DONE:
  - If manual_en=1, delay_setting <= manual_setting each cycle and cal_start is ignored.
  - Else cal_start=1: tap<=0, delay_setting<=0, zero_map<=0, min tracking reset, cal_done<=0, cal_fail<=0, cal_busy<=1, go to SETTLE.
  - The value of delay_setting at start is kept as prev_setting.
- SETTLE:
  - Count SETTLE_CYC cycles, then clear edge counter, error counter and timeout counter, and go to MEASURE.
  - Edges seen during SETTLE are ignored.
- MEASURE:
  - Each edge event increments the edge counter; each hazard increments the error counter. The error counter saturates at 2^ERR_W-1.
  - The timeout counter resets on each edge event.
  - When the edge counter reaches N_EDGES, go to NEXT.
  - If the timeout counter reaches TIMEOUT: delay_setting<=prev_setting, cal_fail<=1, cal_done<=1, cal_busy<=0, go to DONE. zero_map holds partial results.
- NEXT (1 cycle):
  - zero_map[tap] <= (err==0).
  - If err < min_err (strict), min_err<=err and min_tap<=tap, so the lowest tap wins ties.
  - If tap==7, go to EVAL. Else tap<=tap+1, delay_setting<=tap+1, go to SETTLE.
- EVAL (8 cycles, scans t=0..7): tracks the first longest run of consecutive 1s in zero_map, with no wrap-around from tap 7 to tap 0.
  - Final cycle, longest run length L>0 starting at S: delay_setting <= S + (L-1)/2 (integer floor), best_err<=0.
  - Final cycle, L=0: delay_setting<=min_tap, best_err<=min_err, cal_fail<=1.
  - Then cal_done<=1, cal_busy<=0, go to DONE.
- cal_start while cal_busy=1: ignored.
- manual_en going high mid-calibration: has no effect until IDLE/DONE.
- delay_setting changes only at tap transitions, at the EVAL result, at timeout restore, or from the manual override.
- Reset mid-calibration returns immediately to the reset values above.

Test Plan:
- Reset: hold rst_n=0 with toggling inputs -> delay_setting=0, cal_busy=0, cal_done=0, zero_map=0 throughout.
- Clean window: model taps 2..5 hazard-free, all other taps 3 hazards each. Pulse cal_start -> zero_map=8'b0011_1100, delay_setting=3, best_err=0, cal_done=1, cal_fail=0.
- No clean tap: hazard counts per tap (0..7) = 5,4,2,2,6,7,7,7 -> zero_map=0, delay_setting=2, best_err=2, cal_fail=1.
- Timeout: start with delay_setting=4 via manual, then set manual_en=0. Stop bick_fb during tap 1 measurement -> after TIMEOUT cycles cal_fail=1, cal_done=1, delay_setting=4.
- Manual/ignore: manual_en=1, manual_setting=6, pulse cal_start -> delay_setting=6, cal_busy stays 0. Pulse cal_start again while busy during a normal run -> run completes exactly once.
- Edges: zero_map=8'b1000_0001 (two runs of length 1) -> delay_setting=0 (first longest run). zero_map=8'hFF -> delay_setting=3.
